parcel_insn_buffer: RTL and testbench
=====================================

Name: parcel_insn_buffer

Overview:
- Parametrised successor to the single-parcel insn buffer.
- Circular buffer of 16-bit instruction parcels (InsnBufferEntry) between fetch and decode.
- Accepts up to ENQ_WIDTH parcels per cycle.
- Reassembles and issues one RV32C or RV32 instruction per cycle, with pc, fault and interrupt tags.

Parameters:
ENTRY_COUNT, 8, parcel slots; power of two, >= 2*ENQ_WIDTH
ENQ_WIDTH, 2, max parcels enqueued per cycle; 1..4
PC_WIDTH, 32, width of pc field (vaddr_t)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
flush  in  1  discard all contents
enqValid  in  1  enqueue request
enqCount  in  $clog2(ENQ_WIDTH)+1  parcels offered, 1..ENQ_WIDTH
enqEntry  in  ENQ_WIDTH*$bits(InsnBufferEntry)  parcels; lane 0 is oldest
enqReady  out  1  free slots >= ENQ_WIDTH
deqValid  out  1  complete instruction at head
deqReady  in  1  consumer accepts
deqInsn  out  32  instruction; compressed zero-extended
deqPc  out  PC_WIDTH  pc of head parcel
deqCompressed  out  1  head insn[1:0] != 2'b11
deqFault  out  1  fault on any consumed parcel
deqInterruptValid  out  1  head parcel interruptValid
deqInterruptCode  out  4  head parcel interruptCode
entryCount  out  $clog2(ENTRY_COUNT)+1  occupied parcels

Behaviour:
- Reset (async): head=0, tail=0, entryCount=0, deqValid=0; all deq outputs 0. Entry storage is not reset.
- Storage: ENTRY_COUNT-deep circular RAM. Pointers wrap modulo ENTRY_COUNT. entryCount distinguishes full from empty.
- Enqueue fires when enqValid && enqReady.
  - Lanes 0..enqCount-1 are written at tail..tail+enqCount-1 (wrapping).
  - tail += enqCount.
- enqReady = (ENTRY_COUNT - entryCount) >= ENQ_WIDTH.
  - Computed from registered count only; no credit taken for same-cycle dequeue.
- Enqueue with enqCount=0 or enqCount>ENQ_WIDTH is illegal; assertion only.
- Parcel need at head:
  - 1 if head.fault, head.interruptValid, or head.insn[1:0] != 2'b11.
  - Otherwise 2.
- deqValid = entryCount >= need. Outputs are combinational from head and head+1 (wrapped).
- Latency: a parcel enqueued in cycle N is visible at deq in cycle N+1 at the earliest. No enq-to-deq bypass.
- 32-bit reassembly:
  - deqInsn = {parcel[head+1].insn, parcel[head].insn}.
  - deqFault = fault(head) | fault(head+1).
- Compressed issue: deqInsn = {16'h0, parcel[head].insn}.
- Fault or interrupt head: issued as one parcel. deqCompressed reflects insn bits regardless.
- Dequeue fires on deqValid && deqReady: head += need.
- Simultaneous enq and deq: entryCount += enqCount - need, both in the same cycle.
- Flush has priority over enq and deq.
  - head=tail=entryCount=0 next cycle.
  - A same-cycle enqueue is dropped.
  - deqValid=0 in the cycle after flush.
- Reset asserted mid-operation: immediate return to the reset state. No partial writes are retained as valid.
- 32-bit instruction whose upper half is not yet enqueued: deqValid stays 0 until it arrives. No timeout.

Decomposition:
- RafiTypes package:
  - PARCEL_WIDTH=16
  - ENQ_WIDTH default
  - typedef parcel_count_t
  - reuse InsnBufferEntry
  - new struct InsnBufferDeq {insn_t insn; vaddr_t pc; compressed; fault; interruptValid; interruptCode}
- Sub-module parcel_ring_ram: parametrised multi-write-port circular storage with two-port head/head+1 read.
- Pointer/count control stays in the top.

Test Plan:
- ENQ 2 parcels {0x4501 pc 0x80000000, 0x4585 pc 0x80000002}, deqReady=1 -> two cycles of deqValid: deqCompressed=1, deqInsn=0x00004501 then 0x00004585, pcs 0x80000000 / 0x80000002.
- ENQ 0x0093 @0x80000000 alone -> deqValid=0. Next cycle ENQ 0x0010 -> following cycle deqInsn=0x00100093, deqCompressed=0, entryCount 2->0 on dequeue.
- Fill 8 parcels with deqReady=0 -> enqReady drops to 0 at entryCount=7. Enqueue blocked. Single dequeue of a 32-bit insn -> enqReady=1 next cycle. Pointers wrap 7->0 correctly.
- 32-bit insn, upper parcel fault=1 -> deqFault=1 with both parcels consumed. Head parcel interruptValid=1 code 4'h7 -> issued as 1 parcel, deqInterruptCode=7.
- Flush in the same cycle as enqValid with 2 parcels and entryCount=5 -> next cycle entryCount=0, deqValid=0; enqueued data absent.
- Assert rst mid-stream with entryCount=3 -> deqValid=0 and entryCount=0 immediately, without waiting for clk. Normal operation resumes after deassertion.

Source files
------------

// File: rtl/parcel_insn_buffer_pkg.sv
// Shared types for the parcel instruction buffer.
// Entry/deq bundles, parcel widths and the parcel-need rule.
package parcel_insn_buffer_pkg;

  localparam int PARCEL_WIDTH      = 16;
  localparam int ENQ_WIDTH_DEFAULT = 2;
  localparam int VADDR_WIDTH       = 32;

  typedef logic [PARCEL_WIDTH-1:0] parcel_t;
  typedef logic [31:0]             insn_t;
  typedef logic [VADDR_WIDTH-1:0]  vaddr_t;

  typedef logic [$clog2(ENQ_WIDTH_DEFAULT):0] parcel_count_t;

  typedef struct packed {
    vaddr_t     pc;
    parcel_t    insn;
    logic       fault;
    logic       interruptValid;
    logic [3:0] interruptCode;
  } InsnBufferEntry;

  typedef struct packed {
    insn_t      insn;
    vaddr_t     pc;
    logic       compressed;
    logic       fault;
    logic       interruptValid;
    logic [3:0] interruptCode;
  } InsnBufferDeq;

  function automatic logic is_compressed(parcel_t p);
    return p[1:0] != 2'b11;
  endfunction

  // Faulting or interrupt-tagged heads issue alone so the tag
  // never waits on a second parcel that may never arrive.
  function automatic parcel_count_t parcel_need(InsnBufferEntry e);
    if (e.fault || e.interruptValid || is_compressed(e.insn))
      return parcel_count_t'(1);
    return parcel_count_t'(2);
  endfunction

endpackage

// File: rtl/parcel_insn_buffer_ring_ram.sv
// Circular parcel storage: up to ENQ_WIDTH writes per cycle,
// two combinational reads at ptr and ptr+1.
module parcel_ring_ram
  import parcel_insn_buffer_pkg::*;
#(
  parameter int ENTRY_COUNT = 8,
  parameter int ENQ_WIDTH   = 2,
  localparam int PW = $clog2(ENTRY_COUNT),
  localparam int EW = $clog2(ENQ_WIDTH) + 1,
  localparam int EB = $bits(InsnBufferEntry)
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic [PW-1:0]           wr_ptr_i,
  input  logic [EW-1:0]           wr_cnt_i,
  input  logic [ENQ_WIDTH*EB-1:0] wr_data_i,
  input  logic [PW-1:0]           rd_ptr_i,
  output InsnBufferEntry          rd0_o,
  output InsnBufferEntry          rd1_o
);

  InsnBufferEntry mem_q [ENTRY_COUNT];

  // Write the first wr_cnt lanes at consecutive wrapped slots.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int l = 0; l < ENQ_WIDTH; l++) begin
        if (EW'(l) < wr_cnt_i)
          mem_q[wr_ptr_i + PW'(l)] <=
            InsnBufferEntry'(wr_data_i[l*EB +: EB]);
      end
    end
  end

  assign rd0_o = mem_q[rd_ptr_i];
  assign rd1_o = mem_q[rd_ptr_i + PW'(1)];

endmodule

// File: rtl/parcel_insn_buffer.sv
// Parcel ring between fetch and decode; reassembles RV32C/RV32
// instructions and issues one per cycle with pc/fault/irq tags.
module parcel_insn_buffer
  import parcel_insn_buffer_pkg::*;
#(
  parameter int ENTRY_COUNT = 8,
  parameter int ENQ_WIDTH   = ENQ_WIDTH_DEFAULT,
  parameter int PC_WIDTH    = 32,
  localparam int PW = $clog2(ENTRY_COUNT),
  localparam int CW = PW + 1,
  localparam int EW = $clog2(ENQ_WIDTH) + 1,
  localparam int EB = $bits(InsnBufferEntry)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    enqValid,
  input  logic [EW-1:0]           enqCount,
  input  logic [ENQ_WIDTH*EB-1:0] enqEntry,
  output logic                    enqReady,
  output logic                    deqValid,
  input  logic                    deqReady,
  output logic [31:0]             deqInsn,
  output logic [PC_WIDTH-1:0]     deqPc,
  output logic                    deqCompressed,
  output logic                    deqFault,
  output logic                    deqInterruptValid,
  output logic [3:0]              deqInterruptCode,
  output logic [CW-1:0]           entryCount
);

  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  InsnBufferEntry hd0, hd1;
  parcel_count_t  need;
  logic [CW-1:0]  need_w;
  logic           enq_fire, deq_fire;
  InsnBufferDeq   deq;
  logic           unused_hd1;

  parcel_ring_ram #(
    .ENTRY_COUNT (ENTRY_COUNT),
    .ENQ_WIDTH   (ENQ_WIDTH)
  ) u_ram (
    .clk       (clk),
    .we_i      (enq_fire),
    .wr_ptr_i  (tail_q),
    .wr_cnt_i  (enqCount),
    .wr_data_i (enqEntry),
    .rd_ptr_i  (head_q),
    .rd0_o     (hd0),
    .rd1_o     (hd1)
  );

  assign unused_hd1 = ^{hd1.pc, hd1.interruptValid,
                        hd1.interruptCode};

  assign need   = parcel_need(hd0);
  assign need_w = CW'(need);

  // Ready from registered occupancy only: no same-cycle dequeue credit.
  assign enqReady =
    (CW'(ENTRY_COUNT) - count_q) >= CW'(ENQ_WIDTH);
  assign deqValid = (count_q != '0) && (count_q >= need_w);

  assign enq_fire = enqValid && enqReady && !flush;
  assign deq_fire = deqValid && deqReady && !flush;

  // Build the head instruction; all fields read zero when not valid.
  always_comb begin
    deq = '0;
    if (deqValid) begin
      deq.pc             = hd0.pc;
      deq.compressed     = is_compressed(hd0.insn);
      deq.interruptValid = hd0.interruptValid;
      deq.interruptCode  = hd0.interruptCode;
      if (need_w == CW'(1)) begin
        deq.insn  = {16'h0, hd0.insn};
        deq.fault = hd0.fault;
      end else begin
        deq.insn  = {hd1.insn, hd0.insn};
        deq.fault = hd0.fault | hd1.fault;
      end
    end
  end

  assign deqInsn           = deq.insn;
  assign deqPc             = PC_WIDTH'(deq.pc);
  assign deqCompressed     = deq.compressed;
  assign deqFault          = deq.fault;
  assign deqInterruptValid = deq.interruptValid;
  assign deqInterruptCode  = deq.interruptCode;
  assign entryCount        = count_q;

  // Pointer and occupancy update; flush wins over enq and deq.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire)
        tail_d = tail_q + PW'(enqCount);
      if (deq_fire)
        head_d = head_q + PW'(need);
      count_d = count_q
              + (enq_fire ? CW'(enqCount) : '0)
              - (deq_fire ? need_w : '0);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  a_enq_count_legal : assert property (
    @(posedge clk) disable iff (rst)
    enqValid |-> (enqCount != '0 &&
                  enqCount <= EW'(ENQ_WIDTH))
  );

endmodule

// File: tb/tb_parcel_insn_buffer.sv
// Bench for parcel_insn_buffer: directed scenarios plus
// random traffic against a parcel-queue reference model.
module tb_parcel_insn_buffer;
  import parcel_insn_buffer_pkg::*;

  localparam int EC = 8;
  localparam int EWD = 2;
  localparam int EB = $bits(InsnBufferEntry);

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic           enqValid;
  logic [1:0]     enqCount;
  logic [2*EB-1:0] enqEntry;
  logic           enqReady;
  logic           deqValid;
  logic           deqReady;
  logic [31:0]    deqInsn;
  logic [31:0]    deqPc;
  logic           deqCompressed;
  logic           deqFault;
  logic           deqInterruptValid;
  logic [3:0]     deqInterruptCode;
  logic [3:0]     entryCount;

  int n_chk = 0;
  int n_pass = 0;
  InsnBufferEntry q[$];
  InsnBufferEntry z;

  parcel_insn_buffer #(
    .ENTRY_COUNT (EC),
    .ENQ_WIDTH   (EWD),
    .PC_WIDTH    (32)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .enqValid          (enqValid),
    .enqCount          (enqCount),
    .enqEntry          (enqEntry),
    .enqReady          (enqReady),
    .deqValid          (deqValid),
    .deqReady          (deqReady),
    .deqInsn           (deqInsn),
    .deqPc             (deqPc),
    .deqCompressed     (deqCompressed),
    .deqFault          (deqFault),
    .deqInterruptValid (deqInterruptValid),
    .deqInterruptCode  (deqInterruptCode),
    .entryCount        (entryCount)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic InsnBufferEntry mk(
    logic [15:0] insn, logic [31:0] pc,
    logic f = 1'b0, logic iv = 1'b0, logic [3:0] c = 4'h0);
    InsnBufferEntry e;
    e.pc = pc;
    e.insn = insn;
    e.fault = f;
    e.interruptValid = iv;
    e.interruptCode = c;
    return e;
  endfunction

  // Parcels the model would consume now; 0 if nothing issuable.
  function automatic int model_take();
    int n;
    if (q.size() == 0) return 0;
    n = (q[0].fault || q[0].interruptValid ||
         q[0].insn[1:0] != 2'b11) ? 1 : 2;
    return (q.size() >= n) ? n : 0;
  endfunction

  task automatic check_model();
    int n;
    logic [31:0] ei;
    n = model_take();
    chk("count", 64'(entryCount), 64'(q.size()));
    chk("enqReady", 64'(enqReady), 64'((EC - q.size()) >= EWD));
    chk("deqValid", 64'(deqValid), 64'(n != 0));
    if (n != 0) begin
      if (n == 1) ei = {16'h0, q[0].insn};
      else ei = {q[1].insn, q[0].insn};
      chk("insn", 64'(deqInsn), 64'(ei));
      chk("pc", 64'(deqPc), 64'(q[0].pc));
      chk("cmp", 64'(deqCompressed),
          64'(q[0].insn[1:0] != 2'b11));
      chk("fault", 64'(deqFault),
          64'(q[0].fault | (n == 2 && q[1].fault)));
      chk("irqv", 64'(deqInterruptValid),
          64'(q[0].interruptValid));
      chk("irqc", 64'(deqInterruptCode),
          64'(q[0].interruptCode));
    end
  endtask

  task automatic step(bit ev, int cnt, InsnBufferEntry e0,
                      InsnBufferEntry e1, bit dr, bit fl);
    int n;
    bit er;
    enqValid = ev;
    enqCount = 2'(cnt);
    enqEntry = {e1, e0};
    deqReady = dr;
    flush = fl;
    @(negedge clk);
    check_model();
    n = model_take();
    er = (EC - q.size()) >= EWD;
    if (fl) q.delete();
    else begin
      if (dr && n != 0)
        for (int i = 0; i < n; i++) void'(q.pop_front());
      if (ev && er) begin
        q.push_back(e0);
        if (cnt == 2) q.push_back(e1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(bit dr);
    step(1'b0, 1, z, z, dr, 1'b0);
  endtask

  function automatic InsnBufferEntry rnd();
    InsnBufferEntry e;
    e.pc = $urandom;
    e.insn = 16'($urandom);
    if ($urandom_range(0, 1) == 1) e.insn[1:0] = 2'b11;
    e.fault = ($urandom_range(0, 9) == 0);
    e.interruptValid = ($urandom_range(0, 9) == 0);
    e.interruptCode = 4'($urandom);
    return e;
  endfunction

  initial begin
    z = mk(16'h0, 32'h0);
    rst = 1'b1;
    flush = 1'b0;
    enqValid = 1'b0;
    enqCount = 2'd1;
    enqEntry = '0;
    deqReady = 1'b0;
    #2;
    chk("rst_valid", 64'(deqValid), 64'(0));
    chk("rst_count", 64'(entryCount), 64'(0));
    chk("rst_insn", 64'(deqInsn), 64'(0));
    chk("rst_pc", 64'(deqPc), 64'(0));
    chk("rst_flags", 64'({deqCompressed, deqFault,
        deqInterruptValid, deqInterruptCode}), 64'(0));
    chk("rst_ready", 64'(enqReady), 64'(1));
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

    // Two compressed parcels issue one per cycle.
    step(1, 2, mk(16'h4501, 32'h80000000),
         mk(16'h4585, 32'h80000002), 1, 0);
    chk("c1_insn", 64'(deqInsn), 64'h4501);
    chk("c1_pc", 64'(deqPc), 64'h80000000);
    chk("c1_cmp", 64'(deqCompressed), 64'(1));
    idle(1);
    chk("c2_insn", 64'(deqInsn), 64'h4585);
    chk("c2_pc", 64'(deqPc), 64'h80000002);
    idle(1);
    chk("c_empty", 64'(entryCount), 64'(0));

    // 32-bit insn split over two enqueue cycles.
    step(1, 1, mk(16'h0093, 32'h80000000), z, 1, 0);
    chk("half_valid", 64'(deqValid), 64'(0));
    step(1, 1, mk(16'h0010, 32'h80000002), z, 1, 0);
    chk("w_insn", 64'(deqInsn), 64'h00100093);
    chk("w_cmp", 64'(deqCompressed), 64'(0));
    chk("w_count", 64'(entryCount), 64'(2));
    idle(1);
    chk("w_after", 64'(entryCount), 64'(0));

    // Fault in upper half; interrupt-tagged head.
    step(1, 2, mk(16'h0013, 32'h100),
         mk(16'h0000, 32'h102, 1'b1), 0, 0);
    chk("f_fault", 64'(deqFault), 64'(1));
    chk("f_insn", 64'(deqInsn), 64'h00000013);
    idle(1);
    chk("f_both", 64'(entryCount), 64'(0));
    step(1, 2, mk(16'h0073, 32'h200, 1'b0, 1'b1, 4'h7),
         mk(16'h1234, 32'h202), 0, 0);
    chk("i_valid", 64'(deqInterruptValid), 64'(1));
    chk("i_code", 64'(deqInterruptCode), 64'h7);
    chk("i_insn", 64'(deqInsn), 64'h00000073);
    idle(1);
    chk("i_one", 64'(entryCount), 64'(1));
    step(0, 1, z, z, 0, 1);

    // Fill to 7, blocked enqueue, dequeue 32-bit, wrap pointers.
    step(1, 2, mk(16'h00b3, 32'h300), mk(16'h0040, 32'h302), 0, 0);
    step(1, 2, mk(16'h0001, 32'h304), mk(16'h0005, 32'h306), 0, 0);
    step(1, 2, mk(16'h0009, 32'h308), mk(16'h000d, 32'h30a), 0, 0);
    step(1, 1, mk(16'h0011, 32'h30c), z, 0, 0);
    chk("full_cnt", 64'(entryCount), 64'(7));
    chk("full_rdy", 64'(enqReady), 64'(0));
    step(1, 2, mk(16'hdead, 32'h400), mk(16'hbeef, 32'h402), 0, 0);
    chk("blk_cnt", 64'(entryCount), 64'(7));
    idle(1);
    chk("drain_cnt", 64'(entryCount), 64'(5));
    chk("drain_rdy", 64'(enqReady), 64'(1));
    for (int i = 0; i < 6; i++) idle(1);
    step(1, 2, mk(16'h0015, 32'h500), mk(16'h0019, 32'h502), 0, 0);
    idle(1);
    idle(1);

    // Flush with concurrent enqueue at count 5.
    step(1, 2, mk(16'h0021, 32'h600), mk(16'h0025, 32'h602), 0, 0);
    step(1, 2, mk(16'h0029, 32'h604), mk(16'h002d, 32'h606), 0, 0);
    step(1, 1, mk(16'h0031, 32'h608), z, 0, 0);
    chk("pre_flush", 64'(entryCount), 64'(5));
    step(1, 2, mk(16'h0035, 32'h700), mk(16'h0039, 32'h702), 0, 1);
    chk("fl_cnt", 64'(entryCount), 64'(0));
    chk("fl_valid", 64'(deqValid), 64'(0));
    step(1, 1, mk(16'h0045, 32'h800), z, 0, 0);
    chk("fl_new", 64'(deqInsn), 64'h0045);
    chk("fl_new_pc", 64'(deqPc), 64'h800);
    step(0, 1, z, z, 0, 1);

    // Asynchronous reset mid-stream.
    step(1, 2, mk(16'h0049, 32'h900), mk(16'h004d, 32'h902), 0, 0);
    step(1, 1, mk(16'h0051, 32'h904), z, 0, 0);
    chk("pre_rst", 64'(entryCount), 64'(3));
    enqValid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(deqValid), 64'(0));
    chk("arst_cnt", 64'(entryCount), 64'(0));
    q.delete();
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    step(1, 1, mk(16'h0055, 32'ha00), z, 1, 0);
    chk("post_rst", 64'(deqInsn), 64'h0055);

    // Random traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(1, 2),
           rnd(), rnd(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 24) == 0);
    end
    idle(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
